// File: rtl/id_issue_ctrl.sv
// Decode-side issue controller: decodes register usage, interlocks RAW hazards
// against an rd-tracking shift pipeline, and issues into ID/EX registers.
module id_issue_ctrl #(
    parameter int WB_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_id_instruction,
    input  logic [31:0] if_id_pc_out,
    input  logic        if_id_ins_valid,
    input  logic        flush,
    output logic        id_ins_ready,
    output logic [4:0]  id_ex_rs1,
    output logic [4:0]  id_ex_rs2,
    output logic [4:0]  id_ex_rd,
    output logic [31:0] id_ex_pc_out,
    output logic        id_ex_ins_valid,
    output logic        id_stall
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    logic [6:0] opcode;
    logic       rs1_used;
    logic       rs2_used;
    logic       rd_used;
    logic [4:0] rs1_dec;
    logic [4:0] rs2_dec;
    logic [4:0] rd_dec;

    logic       rs1_hit;
    logic       rs2_hit;
    logic       hazard;
    logic       issue;

    logic [WB_LAT-1:0][4:0] pend_q;
    logic [WB_LAT-1:0][4:0] pend_d;

    logic [4:0]  id_ex_rs1_q,       id_ex_rs1_d;
    logic [4:0]  id_ex_rs2_q,       id_ex_rs2_d;
    logic [4:0]  id_ex_rd_q,        id_ex_rd_d;
    logic [31:0] id_ex_pc_out_q,    id_ex_pc_out_d;
    logic        id_ex_ins_valid_q, id_ex_ins_valid_d;

    // Immediate and funct bits play no part in issue decisions.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{if_id_instruction[31:25], if_id_instruction[14:12]};

    assign opcode = if_id_instruction[6:0];

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no
        // path through the case leaves it unassigned and infers a latch.
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        rd_used  = 1'b0;
        case (opcode)
            OPC_OP: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                rd_used  = 1'b1;
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                rs1_used = 1'b1;
                rd_used  = 1'b1;
            end
            OPC_STORE, OPC_BRANCH: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                rd_used = 1'b1;
            end
            default: ;
        endcase
    end

    assign rs1_dec = rs1_used ? if_id_instruction[19:15] : 5'd0;
    assign rs2_dec = rs2_used ? if_id_instruction[24:20] : 5'd0;
    assign rd_dec  = rd_used  ? if_id_instruction[11:7]  : 5'd0;

    // Unused sources decode to x0, and a nonzero source can never equal an empty
    // (zero) entry, so the x0 check alone keeps both from interlocking.
    always_comb begin
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        for (int i = 0; i < WB_LAT; i++) begin
            if (pend_q[i] == rs1_dec) rs1_hit = 1'b1;
            if (pend_q[i] == rs2_dec) rs2_hit = 1'b1;
        end
    end

    assign hazard = if_id_ins_valid & ~flush &
                    ((rs1_hit & (rs1_dec != 5'd0)) | (rs2_hit & (rs2_dec != 5'd0)));
    assign issue  = if_id_ins_valid & ~flush & ~hazard;

    assign id_stall     = hazard;
    assign id_ins_ready = issue | flush | ~if_id_ins_valid;

    always_comb begin
        pend_d    = '0;
        pend_d[0] = issue ? rd_dec : 5'd0;
        for (int i = 1; i < WB_LAT; i++) begin
            pend_d[i] = pend_q[i-1];
        end
    end

    always_comb begin
        id_ex_ins_valid_d = issue;
        id_ex_rs1_d       = issue ? rs1_dec      : 5'd0;
        id_ex_rs2_d       = issue ? rs2_dec      : 5'd0;
        id_ex_rd_d        = issue ? rd_dec       : 5'd0;
        id_ex_pc_out_d    = issue ? if_id_pc_out : 32'd0;
    end

    // NOTE: sequential state uses non-blocking assignments only. The tracker is
    // cleared on reset too: stale entries would interlock the first new instruction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_q            <= '0;
            id_ex_ins_valid_q <= 1'b0;
            id_ex_rs1_q       <= 5'd0;
            id_ex_rs2_q       <= 5'd0;
            id_ex_rd_q        <= 5'd0;
            id_ex_pc_out_q    <= 32'd0;
        end else begin
            pend_q            <= pend_d;
            id_ex_ins_valid_q <= id_ex_ins_valid_d;
            id_ex_rs1_q       <= id_ex_rs1_d;
            id_ex_rs2_q       <= id_ex_rs2_d;
            id_ex_rd_q        <= id_ex_rd_d;
            id_ex_pc_out_q    <= id_ex_pc_out_d;
        end
    end

    assign id_ex_ins_valid = id_ex_ins_valid_q;
    assign id_ex_rs1       = id_ex_rs1_q;
    assign id_ex_rs2       = id_ex_rs2_q;
    assign id_ex_rd        = id_ex_rd_q;
    assign id_ex_pc_out    = id_ex_pc_out_q;

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Self-checking bench for id_issue_ctrl: directed scenarios plus randomized
// traffic against a register-scoreboard model with per-register ready times.
module tb_id_issue_ctrl;

    localparam int WB_LAT = 3;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] if_id_instruction = '0;
    logic [31:0] if_id_pc_out = '0;
    logic        if_id_ins_valid = 1'b0;
    logic        flush = 1'b0;
    logic        id_ins_ready;
    logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
    logic [31:0] id_ex_pc_out;
    logic        id_ex_ins_valid;
    logic        id_stall;

    id_issue_ctrl #(.WB_LAT(WB_LAT)) dut (
        .clk               (clk),
        .rst               (rst),
        .if_id_instruction (if_id_instruction),
        .if_id_pc_out      (if_id_pc_out),
        .if_id_ins_valid   (if_id_ins_valid),
        .flush             (flush),
        .id_ins_ready      (id_ins_ready),
        .id_ex_rs1         (id_ex_rs1),
        .id_ex_rs2         (id_ex_rs2),
        .id_ex_rd          (id_ex_rd),
        .id_ex_pc_out      (id_ex_pc_out),
        .id_ex_ins_valid   (id_ex_ins_valid),
        .id_stall          (id_stall)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: edges since reset, and for each register the edge count at which
    // its latest in-flight writer has left the tracker.
    int cyc = 0;
    int ready_at [32];

    logic        obs_stall, obs_ready, exp_stall, exp_ready;
    logic [47:0] obs_regs, exp_regs;

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'h2a, rs2, rs1, 3'b101, rd, op};
    endfunction

    function automatic logic [47:0] regs(input logic v, input logic [4:0] r1,
                                         input logic [4:0] r2, input logic [4:0] rd,
                                         input logic [31:0] pc);
        return {v, r1, r2, rd, pc};
    endfunction

    // {rs1 read, rs2 read, rd written} per opcode class.
    function automatic logic [2:0] usage(input logic [6:0] op);
        if (op == OP) return 3'b111;
        if (op == OPIMM || op == LOAD || op == JALR) return 3'b101;
        if (op == STORE || op == BRANCH) return 3'b110;
        if (op == LUI || op == AUIPC || op == JAL) return 3'b001;
        return 3'b000;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 32; r++) ready_at[r] = 0;
        cyc = 0;
    endtask

    task automatic step(input logic [31:0] ins, input logic [31:0] pc,
                        input logic v, input logic f);
        logic [2:0] u;
        logic [4:0] r1, r2, rd;
        logic       haz, iss;
        if_id_instruction = ins;
        if_id_pc_out      = pc;
        if_id_ins_valid   = v;
        flush             = f;
        u   = usage(ins[6:0]);
        r1  = u[2] ? ins[19:15] : 5'd0;
        r2  = u[1] ? ins[24:20] : 5'd0;
        rd  = u[0] ? ins[11:7]  : 5'd0;
        haz = v && !f && ((r1 != 0 && ready_at[r1] > cyc) || (r2 != 0 && ready_at[r2] > cyc));
        iss = v && !f && !haz;
        exp_stall = haz;
        exp_ready = iss || f || !v;
        exp_regs  = iss ? regs(1'b1, r1, r2, rd, pc) : 48'd0;
        #1;
        obs_stall = id_stall;
        obs_ready = id_ins_ready;
        @(posedge clk);
        #1;
        obs_regs = {id_ex_ins_valid, id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_pc_out};
        if (iss && rd != 0) ready_at[rd] = cyc + 1 + WB_LAT;
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i <= WB_LAT; i++) step(32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        if_id_instruction = mk(OP, 5'd3, 5'd1, 5'd2);
        if_id_pc_out      = 32'h40;
        if_id_ins_valid   = 1'b1;
        flush             = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({id_ex_ins_valid, id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_pc_out} !== 48'd0) begin
            n_errors++;
            $display("FAIL reset_regs: got %h expected %h",
                     {id_ex_ins_valid, id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_pc_out}, 48'd0);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({id_stall, id_ins_ready} !== 2'b01) begin
            n_errors++;
            $display("FAIL reset_comb: got stall/ready %b%b expected 01", id_stall, id_ins_ready);
        end
        model_clear();
    endtask

    task automatic test_independent();
        drain();
        step(mk(OPIMM, 5'd1, 5'd0, 5'd1), 32'h100, 1'b1, 1'b0);
        n_checks++;
        if ({obs_stall, obs_ready, obs_regs} !== {2'b01, regs(1'b1, 5'd0, 5'd0, 5'd1, 32'h100)}) begin
            n_errors++;
            $display("FAIL indep_first: got %b%b %h", obs_stall, obs_ready, obs_regs);
        end
        step(mk(OPIMM, 5'd2, 5'd0, 5'd2), 32'h104, 1'b1, 1'b0);
        n_checks++;
        if ({obs_stall, obs_ready, obs_regs} !== {2'b01, regs(1'b1, 5'd0, 5'd0, 5'd2, 32'h104)}) begin
            n_errors++;
            $display("FAIL indep_second: got %b%b %h", obs_stall, obs_ready, obs_regs);
        end
    endtask

    task automatic test_raw_stall();
        drain();
        step(mk(OP, 5'd3, 5'd1, 5'd2), 32'h200, 1'b1, 1'b0);
        n_checks++;
        if (obs_regs !== regs(1'b1, 5'd1, 5'd2, 5'd3, 32'h200)) begin
            n_errors++;
            $display("FAIL raw_producer: got %h", obs_regs);
        end
        for (int i = 0; i < WB_LAT; i++) begin
            step(mk(OP, 5'd4, 5'd3, 5'd1), 32'h204, 1'b1, 1'b0);
            n_checks++;
            if ({obs_stall, obs_ready, obs_regs} !== {2'b10, 48'd0}) begin
                n_errors++;
                $display("FAIL raw_stall_%0d: got %b%b %h expected stall=1 ready=0 bubble",
                         i, obs_stall, obs_ready, obs_regs);
            end
        end
        step(mk(OP, 5'd4, 5'd3, 5'd1), 32'h204, 1'b1, 1'b0);
        n_checks++;
        if ({obs_stall, obs_ready, obs_regs} !== {2'b01, regs(1'b1, 5'd3, 5'd1, 5'd4, 32'h204)}) begin
            n_errors++;
            $display("FAIL raw_issue: got %b%b %h", obs_stall, obs_ready, obs_regs);
        end
    endtask

    task automatic test_unused_fields();
        drain();
        step(mk(OPIMM, 5'd7, 5'd0, 5'd0), 32'h300, 1'b1, 1'b0);
        // Store: rd field carries immediate bits (x7 pattern) that must be ignored.
        step(mk(STORE, 5'd7, 5'd6, 5'd5), 32'h304, 1'b1, 1'b0);
        n_checks++;
        if ({obs_stall, obs_regs} !== {1'b0, regs(1'b1, 5'd6, 5'd5, 5'd0, 32'h304)}) begin
            n_errors++;
            $display("FAIL unused_store: got %b %h", obs_stall, obs_regs);
        end
        step(mk(OPIMM, 5'd8, 5'd0, 5'd0), 32'h308, 1'b1, 1'b0);
        step(mk(LUI, 5'd8, 5'd8, 5'd8), 32'h30c, 1'b1, 1'b0);
        n_checks++;
        if ({obs_stall, obs_regs} !== {1'b0, regs(1'b1, 5'd0, 5'd0, 5'd8, 32'h30c)}) begin
            n_errors++;
            $display("FAIL unused_lui: got %b %h", obs_stall, obs_regs);
        end
        step(mk(SYSTEM, 5'd8, 5'd8, 5'd8), 32'h310, 1'b1, 1'b0);
        n_checks++;
        if ({obs_stall, obs_regs} !== {1'b0, regs(1'b1, 5'd0, 5'd0, 5'd0, 32'h310)}) begin
            n_errors++;
            $display("FAIL unused_other: got %b %h", obs_stall, obs_regs);
        end
    endtask

    task automatic test_x0();
        drain();
        step(mk(OPIMM, 5'd0, 5'd0, 5'd0), 32'h400, 1'b1, 1'b0);
        n_checks++;
        if (obs_regs !== regs(1'b1, 5'd0, 5'd0, 5'd0, 32'h400)) begin
            n_errors++;
            $display("FAIL x0_producer: got %h", obs_regs);
        end
        step(mk(OP, 5'd9, 5'd0, 5'd0), 32'h404, 1'b1, 1'b0);
        n_checks++;
        if ({obs_stall, obs_ready, obs_regs} !== {2'b01, regs(1'b1, 5'd0, 5'd0, 5'd9, 32'h404)}) begin
            n_errors++;
            $display("FAIL x0_consumer: got %b%b %h", obs_stall, obs_ready, obs_regs);
        end
    endtask

    task automatic test_flush_stall();
        drain();
        step(mk(OP, 5'd10, 5'd11, 5'd12), 32'h500, 1'b1, 1'b0);
        step(mk(OP, 5'd13, 5'd10, 5'd0), 32'h504, 1'b1, 1'b0);
        n_checks++;
        if ({obs_stall, obs_ready, obs_regs} !== {2'b10, 48'd0}) begin
            n_errors++;
            $display("FAIL flush_pre_stall: got %b%b %h", obs_stall, obs_ready, obs_regs);
        end
        step(mk(OP, 5'd13, 5'd10, 5'd0), 32'h504, 1'b1, 1'b1);
        n_checks++;
        if ({obs_stall, obs_ready, obs_regs} !== {2'b01, 48'd0}) begin
            n_errors++;
            $display("FAIL flush_cycle: got %b%b %h", obs_stall, obs_ready, obs_regs);
        end
        // Reads x13, which the flushed instruction would have written.
        step(mk(OPIMM, 5'd14, 5'd13, 5'd1), 32'h508, 1'b1, 1'b0);
        n_checks++;
        if ({obs_stall, obs_ready, obs_regs} !== {2'b01, regs(1'b1, 5'd13, 5'd0, 5'd14, 32'h508)}) begin
            n_errors++;
            $display("FAIL flush_next: got %b%b %h", obs_stall, obs_ready, obs_regs);
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [10];
        logic [6:0] op;
        logic [31:0] ins;
        ops = '{OP, OPIMM, LOAD, JALR, STORE, BRANCH, LUI, AUIPC, JAL, SYSTEM};
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                rst = 1'b0;
                if_id_instruction = mk(OP, 5'd1, 5'd1, 5'd1);
                if_id_ins_valid   = 1'b1;
                flush             = 1'b0;
                @(posedge clk);
                #1;
                rst = 1'b1;
                model_clear();
                n_checks++;
                if ({id_ex_ins_valid, id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_pc_out} !== 48'd0) begin
                    n_errors++;
                    $display("FAIL rand_midreset: registered outputs not cleared");
                end
            end
            op  = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
            ins = mk(op, 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)));
            ins[31:25] = 7'($urandom);
            step(ins, $urandom, $urandom_range(0, 5) != 0, $urandom_range(0, 9) == 0);
            n_checks++;
            if ({obs_stall, obs_ready} !== {exp_stall, exp_ready}) begin
                n_errors++;
                $display("FAIL rand_comb[%0d]: got stall/ready %b%b expected %b%b",
                         n, obs_stall, obs_ready, exp_stall, exp_ready);
            end
            n_checks++;
            if (obs_regs !== exp_regs) begin
                n_errors++;
                $display("FAIL rand_regs[%0d]: got %h expected %h", n, obs_regs, exp_regs);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_independent();
        test_raw_stall();
        test_unused_fields();
        test_x0();
        test_flush_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/id_issue_ctrl.md
# id_issue_ctrl

Decode-side issue controller between the IF/ID and ID/EX stages of the pipelined core. It takes the instruction from IF/ID and works out which of rs1/rs2/rd it actually uses. It interlocks on read-after-write hazards against instructions still in flight, using an rd-tracking shift pipeline. It then issues the instruction into its own ID/EX output registers, or inserts a bubble and back-pressures IF/ID.

## Interface

- WB_LAT, 3: number of clock edges from issue until an instruction's rd is written back and readable (valid range 1..8).
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- if_id_instruction  input  32  instruction word from IF/ID.
- if_id_pc_out  input  32  PC of that instruction.
- if_id_ins_valid  input  1  instruction word is valid.
- flush  input  1  kill the instruction currently presented (branch redirect).
- id_ins_ready  output  1  instruction is consumed this cycle; IF/ID may advance.
- id_ex_rs1  output  5  issued rs1 (0 if unused).
- id_ex_rs2  output  5  issued rs2 (0 if unused).
- id_ex_rd  output  5  issued rd (0 if unused).
- id_ex_pc_out  output  32  issued PC.
- id_ex_ins_valid  output  1  ID/EX slot holds a real instruction.
- id_stall  output  1  hazard interlock active this cycle (combinational).

## Operation

Field usage is decoded from opcode [6:0]:
- 0110011 (OP): rs1, rs2, rd.
- 0010011 (OP-IMM), 0000011 (LOAD), 1100111 (JALR): rs1, rd.
- 0100011 (STORE), 1100011 (BRANCH): rs1, rs2.
- 0110111 (LUI), 0010111 (AUIPC), 1101111 (JAL): rd.
- Any other opcode: no registers used; all three fields are forced to 0; the instruction still issues.

Unused fields are forced to 0.

In-flight tracker:
- Shift register pend[0..WB_LAT-1], each entry 5 bits.
- Every edge: pend[i] <= pend[i-1] for i ≥ 1.
- pend[0] <= rd on an issue edge, otherwise 0.
- The oldest entry falls out after WB_LAT edges. The tracker never stalls or flushes; in-flight instructions always complete.

Hazard and issue rules:
- hazard = if_id_ins_valid & !flush & ((rs1_used & rs1≠0 & rs1 matches any pend entry) | (rs2_used & rs2≠0 & rs2 matches any pend entry)).
- Register x0 never causes a hazard, and an entry of 0 never matches.
- id_stall = hazard.
- issue = if_id_ins_valid & !flush & !hazard.
- id_ins_ready = issue | flush | !if_id_ins_valid. An empty slot or a flushed slot is consumed; a stalled slot is held.

Output registers:
- Issue edge: load the decoded rs1/rs2/rd, if_id_pc_out, and id_ex_ins_valid=1.
- Any non-issue edge (stall, flush, invalid input): bubble. id_ex_ins_valid=0, rs1/rs2/rd=0, pc=0.

Flush has priority over hazard. A flushed instruction is never issued and is never entered into the tracker.

## Timing

- Reset (rst=0 at an edge): all outputs registered to 0 and all pend entries to 0. Combinational outputs then settle to id_stall=0 and id_ins_ready=1.
- Reset asserted mid-operation discards all in-flight tracking. The first instruction after reset issues without interlock.
- Issue latency: 1 edge from IF/ID presentation to ID/EX output.
- A dependent instruction presented in the cycle immediately after its producer issues stalls for exactly WB_LAT cycles and issues on the (WB_LAT+1)th edge.
- A dependent presented k cycles after its producer stalls max(0, WB_LAT−k+1) cycles.
- A producer whose rd=0 creates no pend entry that can match.
- The same register written by several in-flight instructions: the stall lasts until the last of them leaves pend.
- id_stall and id_ins_ready are combinational from the inputs and pend. id_ex_* are registered.

## Test plan

- Reset: hold rst=0 for 2 edges with valid inputs present → all id_ex_* = 0, id_stall=0, id_ins_ready=1.
- Independent stream: issue addi x1,x0,1, then addi x2,x0,2, back-to-back → both issue on consecutive edges, id_ex_rd=1 then 2, no stall.
- RAW stall, WB_LAT=3: add x3,x1,x2 followed immediately by sub x4,x3,x1 → id_stall=1 and id_ins_ready=0 for 3 cycles, 3 bubbles (id_ex_ins_valid=0), sub issues on the 4th edge with rs1=3, rs2=1, rd=4.
- Unused-field check: sw x5,0(x6) after a producer writing x7 → no stall; id_ex_rd=0, rs1=6, rs2=5. lui x8 after a producer writing x8 → no stall.
- x0 check: addi x0,x0,0 followed by add x9,x0,x0 → no stall.
- Flush during stall: a dependent is stalled and flush=1 for one cycle → id_ins_ready=1, id_stall=0, bubble issued, pend unchanged. The next independent instruction issues on the following edge.
